// File: rtl/hack_screen_scanout.sv
// Hack screen memory: CPU bus responder plus a raster-order 1-bit pixel
// scanout. Each screen word is fetched into a shift register, then sent
// one pixel per transfer, LSB first. This gives one bubble cycle per word.
module hack_screen_scanout #(
  parameter int unsigned BASE_ADDR     = 16384,
  parameter int unsigned ROWS          = 256,
  parameter int unsigned WORDS_PER_ROW = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_load,
  input  logic [15:0] bus_in,
  input  logic [14:0] bus_address,
  output logic        bus_sel,
  output logic [15:0] bus_out,
  input  logic        pix_enable,
  input  logic        pix_ready,
  output logic        pix_valid,
  output logic        pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        frame_done
);
  localparam int unsigned DEPTH = ROWS * WORDS_PER_ROW;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned WW    = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS_PER_ROW - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_e;

  logic [15:0]   mem [DEPTH];
  logic [15:0]   addr_ext;
  logic [AW-1:0] bus_idx, fetch_idx;

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [WW-1:0] word_q, word_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   shreg_q, shreg_d;
  logic          pix_valid_q, pix_valid_d;
  logic          pix_sof_q, pix_sof_d;
  logic          pix_eol_q, pix_eol_d;
  logic          frame_done_q, frame_done_d;
  logic          xfer;

  assign addr_ext  = {1'b0, bus_address};
  assign bus_sel   = (addr_ext >= 16'(BASE_ADDR)) && (addr_ext <= 16'(BASE_ADDR + DEPTH - 1));
  assign bus_idx   = AW'(addr_ext - 16'(BASE_ADDR));
  assign bus_out   = bus_sel ? mem[bus_idx] : 16'h0000;
  assign fetch_idx = AW'(32'(row_q) * WORDS_PER_ROW + 32'(word_q));

  // CPU writes into screen memory. Contents survive reset.
  always_ff @(posedge clk) begin
    if (bus_load && bus_sel) mem[bus_idx] <= bus_in;
  end

  // Scanout next-state: counters, shift register and registered stream flags.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    word_d       = word_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    frame_done_d = 1'b0;
    xfer         = pix_valid_q && pix_ready;
    case (state_q)
      IDLE: if (pix_enable) begin
        row_d   = '0;
        word_d  = '0;
        bit_d   = '0;
        state_d = FETCH;
      end
      // Array read sees the pre-edge contents, so a same-cycle CPU write
      // to this word lands in memory but not in this snapshot.
      FETCH: begin
        shreg_d = mem[fetch_idx];
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: if (xfer) begin
        shreg_d = {1'b0, shreg_q[15:1]};
        bit_d   = bit_q + 4'd1;
        if (bit_q == 4'hF) begin
          state_d = FETCH;
          if (word_q != LAST_WORD) begin
            word_d = word_q + WW'(1);
          end else begin
            word_d = '0;
            if (row_q != LAST_ROW) begin
              row_d = row_q + RW'(1);
            end else begin
              row_d        = '0;
              frame_done_d = 1'b1;
              if (!pix_enable) state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Flags follow the next position so they are registered alongside valid.
    pix_valid_d = (state_d == SHIFT);
    pix_sof_d   = pix_valid_d && (row_d == '0) && (word_d == '0) && (bit_d == 4'h0);
    pix_eol_d   = pix_valid_d && (word_d == LAST_WORD) && (bit_d == 4'hF);
  end

  // Scanout state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      row_q        <= '0;
      word_q       <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      pix_valid_q  <= 1'b0;
      pix_sof_q    <= 1'b0;
      pix_eol_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      word_q       <= word_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      pix_valid_q  <= pix_valid_d;
      pix_sof_q    <= pix_sof_d;
      pix_eol_q    <= pix_eol_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_data   = shreg_q[0];
  assign pix_sof    = pix_sof_q;
  assign pix_eol    = pix_eol_q;
  assign frame_done = frame_done_q;
endmodule
